// File: rtl/cordic_log.sv
// cordic_log: iterative shift-and-add natural log, unsigned Q16.16 in, Q32.32 out.
// Latency: start sampled at E0, valid strobes for one cycle after E33; next start at E34.
// Handshake: en is honoured only in IDLE (no queueing); busy covers CALC and DONE.
// Optional build macro LOG_FRAC_INPUT_EN: accept 0 < y < 1.0 via a 2^16 prescale
// and return a two's-complement negative result.
module cordic_log (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [31:0]   y_in,
  input  logic [2047:0] lookup,
  output logic [63:0]   x_out,
  output logic          valid,
  output logic          busy,
  output logic          range_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [63:0] ONE_Q32 = 64'h0000_0001_0000_0000;

  state_t      state;
  state_t      state_nxt;

  logic [4:0]  counter;   // step index k during CALC
  logic [63:0] w;         // target operand, Q32.32
  logic [63:0] z;         // running product of accepted factors, Q32.32
  logic [63:0] acc;       // running sum of ln(accepted factors), Q32.32
  logic        err;       // operand latched as out of range

`ifdef LOG_FRAC_INPUT_EN
  logic        pre;       // operand was prescaled by 2^16
  logic        op_pre;
  logic [63:0] tab_0;
`endif

  logic        load;
  logic        step;
  logic        finish;
  logic        op_err;
  logic [63:0] op_w;
  logic [4:0]  tab_idx;
  logic [63:0] tab_k;
  logic [79:0] z_ext;
  logic [79:0] w_ext;
  logic [79:0] cand;
  logic        take;
  logic [63:0] result;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: one pass through CALC is exactly 32 cycles
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = CALC;
      CALC:    if (counter == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode from the current state
  always_comb begin
    busy   = (state == CALC) || (state == DONE);
    load   = (state == IDLE) && en;
    step   = (state == CALC);
    finish = (state == DONE);
  end

  // Operand conditioning: range check and placement of y into Q32.32
  always_comb begin
`ifdef LOG_FRAC_INPUT_EN
    op_err = (y_in == 32'h0);
    op_pre = (y_in < 32'h0001_0000);
    op_w   = op_pre ? {y_in, 32'h0} : {16'h0, y_in, 16'h0};
`else
    op_err = (y_in < 32'h0001_0000);
    op_w   = {16'h0, y_in, 16'h0};
`endif
  end

  // Candidate factor for step k and the table entry it would add.
  // Steps 0..15 try z*2^(16-k); steps 16..31 try z*(1+2^-(k-15)).
  // The 80-bit width lets z<<16 of a near-2^16 product compare without wrap.
  always_comb begin
    tab_idx = ~counter;                         // tab[k] lives at slot 31-k
    tab_k   = lookup[{tab_idx, 6'b0} +: 64];
    z_ext   = {16'h0, z};
    w_ext   = {16'h0, w};
    if (!counter[4]) begin
      cand = z_ext << (5'd16 - counter);
    end else begin
      cand = z_ext + (z_ext >> (counter - 5'd15));
    end
    take = !err && (cand <= w_ext);
  end

  // Final result selection; a prescaled operand removes the 16*ln2 bias
  always_comb begin
`ifdef LOG_FRAC_INPUT_EN
    tab_0  = lookup[2047:1984];
    result = pre ? (acc - tab_0) : acc;
`else
    result = acc;
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      x_out     <= 64'h0;
      valid     <= 1'b0;
      range_err <= 1'b0;
      counter   <= 5'd0;
      acc       <= 64'h0;
      z         <= ONE_Q32;
      w         <= 64'h0;
      err       <= 1'b0;
`ifdef LOG_FRAC_INPUT_EN
      pre       <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      if (load) begin
        w       <= op_w;
        z       <= ONE_Q32;
        acc     <= 64'h0;
        counter <= 5'd0;
        err     <= op_err;
`ifdef LOG_FRAC_INPUT_EN
        pre     <= op_pre;
`endif
      end
      if (step) begin
        if (take) begin
          z   <= cand[63:0];
          acc <= acc + tab_k;
        end
        counter <= counter + 5'd1;
      end
      if (finish) begin
        x_out     <= err ? 64'h0 : result;
        range_err <= err;
        valid     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cordic_log.sv
// Bench for cordic_log: scoreboard of expected results built from a real-valued
// ln model, popped on each valid strobe; also checks latency, busy span,
// continuous-start throughput, ignored mid-run starts and mid-run reset.
module tb_cordic_log;

  localparam logic [63:0] TOL = 64'h0000_0000_0002_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [31:0]   y_in;
  logic [2047:0] lookup;
  logic [63:0]   x_out;
  logic          valid;
  logic          busy;
  logic          range_err;

  typedef struct {
    logic [31:0] y;
    logic [63:0] x;
    logic [63:0] tol;
    logic        err;
    int          start;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  cordic_log dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .y_in      (y_in),
    .lookup    (lookup),
    .x_out     (x_out),
    .valid     (valid),
    .busy      (busy),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] adiff(input logic [63:0] a, input logic [63:0] b);
    longint d;
    d = longint'(a) - longint'(b);
    if (d < 0) d = -d;
    return 64'(d);
  endfunction

  // Reference: ln(y) in Q32.32 from real arithmetic
  function automatic exp_t model(input logic [31:0] y, input int st);
    exp_t e;
    real  r;
    logic bad;
`ifdef LOG_FRAC_INPUT_EN
    bad = (y == 32'h0);
`else
    bad = (y < 32'h0001_0000);
`endif
    e.y     = y;
    e.err   = bad;
    e.start = st;
    if (bad) begin
      e.x   = 64'h0;
      e.tol = 64'h0;
    end else begin
      r     = y;
      r     = $ln(r / 65536.0) * 4294967296.0;
      e.x   = 64'(longint'(r));
      e.tol = TOL;
    end
    return e;
  endfunction

  // Compare each valid strobe against the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [63:0] d;
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        d = adiff(x_out, e.x);
        check($sformatf("range_err y=%h", e.y), {63'b0, range_err}, {63'b0, e.err});
        check($sformatf("x_out y=%h (dut %h ref %h tol %h)", e.y, x_out, e.x, e.tol),
              {63'b0, (d > e.tol)}, 64'd0);
        check($sformatf("latency y=%h", e.y), 64'(cyc - e.start), 64'd33);
      end
    end
  end

  task automatic start_op(input exp_t e);
    @(negedge clk);
    en   = 1'b1;
    y_in = e.y;
    e.start = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    en   = 1'b0;
    y_in = $urandom;
  endtask

  task automatic start_model(input logic [31:0] y);
    start_op(model(y, 0));
  endtask

  task automatic start_fixed(input logic [31:0] y, input logic [63:0] x,
                             input logic [63:0] tol, input logic err);
    exp_t e;
    e.y = y; e.x = x; e.tol = tol; e.err = err; e.start = 0;
    start_op(e);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    real t;
    int  bc;
    int  g;
    int  base;
    exp_t e;

    for (int k = 0; k < 32; k++) begin
      if (k < 16) t = (16 - k) * $ln(2.0) * 4294967296.0;
      else        t = $ln(1.0 + 1.0 / (2.0 ** (k - 15))) * 4294967296.0;
      lookup[(31 - k) * 64 +: 64] = 64'(longint'(t));
    end

    rst  = 1'b1;
    en   = 1'b0;
    y_in = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_x_out",     x_out,               64'h0);
    check("reset_valid",     {63'b0, valid},      64'h0);
    check("reset_busy",      {63'b0, busy},       64'h0);
    check("reset_range_err", {63'b0, range_err},  64'h0);
    rst = 1'b0;

    // 1.0 gives exactly zero; busy spans the 33 cycles before the strobe
    start_fixed(32'h0001_0000, 64'h0, 64'h0, 1'b0);
    bc = 0;
    g  = 0;
    while (!valid && g < 40) begin
      if (busy) bc++;
      @(negedge clk);
      g++;
    end
    check("busy_cycles", 64'(bc), 64'd33);
    check("busy_in_valid_cycle", {63'b0, busy}, 64'd0);
    wait_drain(60);

    start_fixed(32'h0002_0000, 64'h0000_0000_B172_17F7, TOL, 1'b0);
    wait_drain(60);
    start_fixed(32'h0002_B7E1, 64'h0000_0001_0000_0000, TOL, 1'b0);
    wait_drain(60);
    start_fixed(32'hFFFF_FFFF, 64'h0000_000B_1721_7F7D, TOL, 1'b0);
    wait_drain(60);

    // Range edges
    start_fixed(32'h0, 64'h0, 64'h0, 1'b1);
    wait_drain(60);
`ifdef LOG_FRAC_INPUT_EN
    start_fixed(32'h0000_8000, 64'hFFFF_FFFF_4E8D_E809, TOL, 1'b0);
`else
    start_fixed(32'h0000_8000, 64'h0, 64'h0, 1'b1);
`endif
    wait_drain(60);
    start_model(32'h0000_FFFF);
    wait_drain(60);

    // Random operands across the accepted range and below 1.0
    for (int i = 0; i < 6; i++) begin
      start_model($urandom_range(32'hFFFF_FFFF, 32'h0001_0000));
      wait_drain(60);
    end
    for (int i = 0; i < 2; i++) begin
      start_model($urandom_range(32'h0000_FFFF, 32'h1));
      wait_drain(60);
    end

    // en held high: three back-to-back operations, 34 cycles apart
    @(negedge clk);
    en   = 1'b1;
    y_in = 32'h0003_0000;
    base = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      e = model(32'h0003_0000, base + 34 * i);
      sb.push_back(e);
    end
    repeat (69) @(negedge clk);
    en = 1'b0;
    wait_drain(120);

    // Start request mid-CALC is ignored
    start_model(32'h0123_4567);
    repeat (10) @(negedge clk);
    en   = 1'b1;
    y_in = 32'h0000_0002;
    @(negedge clk);
    en   = 1'b0;
    wait_drain(60);
    repeat (40) @(negedge clk);

    // Reset sampled at E10 aborts the operation with no strobe
    start_model(32'h00A0_0000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_busy",      {63'b0, busy},      64'h0);
    check("midrst_valid",     {63'b0, valid},     64'h0);
    check("midrst_x_out",     x_out,              64'h0);
    check("midrst_range_err", {63'b0, range_err}, 64'h0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    start_model(32'h0007_0000);
    wait_drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_log.md
Name: cordic_log

Overview:
- Iterative shift-and-add natural-logarithm unit; the inverse direction of the team's exponential CORDIC.
- Shares the same 32-entry Q32.32 ln-constant lookup bus, so one table ROM feeds both blocks.
- Input is an unsigned Q16.16 operand. Output is ln(operand) in Q32.32 after a fixed 32-step iteration.
- Sits beside the exp unit in the math datapath, with the same start/valid handshake.

Parameters:
- None. Widths are fixed by the shared table format: 32 entries × 64 bits.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  start; sampled only in IDLE.
- y_in  in  32  operand, unsigned Q16.16.
- lookup  in  2048  ln table, packed; tab[31-i] = lookup[i*64+63 : i*64], so tab[0] occupies [2047:1984].
- x_out  out  64  result, Q32.32 (two's complement when LOG_FRAC_INPUT_EN is defined).
- valid  out  1  one-cycle result strobe.
- busy  out  1  high in CALC and DONE.
- range_err  out  1  operand out of range; qualified by valid.

Behaviour:
- Reset values (override all other activity on the edge): x_out=0, valid=0, busy=0, range_err=0, state=IDLE, counter=0, acc=0, z=1.0 (64'h0000_0001_0000_0000).
- Table contents, Q32.32:
  - tab[k] = (16-k)·ln2 for k=0..15.
  - tab[k] = ln(1+2^-(k-15)) for k=16..31.
- States: IDLE → CALC → DONE → IDLE.
- IDLE:
  - valid=0.
  - On en=1: w ← {16'h0, y_in, 16'h0}, z ← 1.0, acc ← 0, counter ← 0, state ← CALC.
  - If y_in < 32'h0001_0000: latch err=1, else err=0.
- CALC, step k = counter:
  - cand = z<<(16-k) for k<16; cand = z + (z>>(k-15)) for k≥16.
  - cand is computed 80 bits wide, with no truncation.
  - If err=0 and cand ≤ w (zero-extended): z ← cand[63:0], acc ← acc + tab[k].
  - counter increments each cycle. After k=31, state ← DONE.
  - Exactly 32 CALC cycles.
- DONE: x_out ← err ? 0 : acc; range_err ← err; valid ← 1 for one cycle; state ← IDLE.
- Latency:
  - en sampled at edge E0; valid high between E33 and E34.
  - Earliest next start is sampled at E34.
- en in CALC or DONE: ignored, no queueing. y_in is don't-care after E0.
- x_out holds its value until the next DONE. range_err updates only in DONE.
- rst mid-operation: returns to IDLE with the reset values. No valid for the aborted operation.
- Accuracy: |x_out − ln(y)| ≤ 2^-15 (0x0000_0000_0002_0000) for 1.0 ≤ y ≤ 0xFFFF.FFFF.

Optional Feature:
- LOG_FRAC_INPUT_EN defined:
  - Operands 0 < y_in < 1.0 are accepted.
  - In IDLE the operand is prescaled: w ← {y_in, 32'h0}, i.e. ×2^16. A prescale flag is latched.
  - In DONE: x_out ← acc − tab[0], the two's-complement negative result.
  - range_err is raised only for y_in == 0.
- Not defined:
  - Any y_in < 1.0, including 0, gives range_err=1 and x_out=0 at valid.

Test Plan:
- y_in=32'h0001_0000 (1.0) → valid at E33, x_out=0, range_err=0, busy high E1–E33.
- y_in=32'h0002_0000 (2.0) → x_out ≈ 64'h0000_0000_B172_17F7 within ±0x2_0000. y_in=32'h0002_B7E1 (e) → x_out ≈ 64'h0000_0001_0000_0000 within ±0x2_0000.
- y_in=32'hFFFF_FFFF → x_out ≈ 64'h0000_000B_1721_7F7D within ±0x2_0000. Confirms the 80-bit candidate path has no overflow.
- Range check:
  - y_in=0 → range_err=1, x_out=0.
  - y_in=32'h0000_8000 (0.5) with macro undefined → range_err=1.
  - Same input with LOG_FRAC_INPUT_EN → range_err=0, x_out ≈ 64'hFFFF_FFFF_4E8D_E809 (−ln2) ±0x2_0000.
- Handshake:
  - en held high continuously → results strobe every 34 cycles.
  - en pulsed mid-CALC → ignored, result unchanged.
- Reset mid-run: rst at E10 → state IDLE, busy=0, valid=0, x_out=0. No valid pulse follows. A new start computes correctly.
